output_argmax: RTL and testbench

- Classifier stage directly downstream of the final network layer.
- Consumes the packed neuron-output vector and its valid strobe, and sequentially scans the elements one per clock.
- Reports the index and value of the largest signed element, i.e. the predicted class.
- Registers the input vector on acceptance, so the upstream layer may change its outputs during the scan.

---
 rtl/output_argmax.sv | 132 +++++++++++++
 tb/tb_output_argmax.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_argmax.sv
`default_nettype none
// ============================================================================
// Module   : output_argmax
// Brief    : Sequential signed argmax over a registered neuron-output vector.
// Revision : 1.0 - initial release
// ============================================================================
module output_argmax #(
    parameter int dataWidth  = 16,
    parameter int numInputs  = 10,
    parameter int indexWidth = $clog2(numInputs)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [dataWidth*numInputs-1:0] argIn,
    input  logic                           argInValid,
    output logic [indexWidth-1:0]          argOut,
    output logic [dataWidth-1:0]           argMaxValue,
    output logic                           argOutValid,
    output logic                           busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [indexWidth:0] c_last_count = (indexWidth + 1)'(numInputs - 1);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [dataWidth*numInputs-1:0] r_vec;
    logic [dataWidth*numInputs-1:0] w_vec_next;
    logic [indexWidth:0]            r_count;
    logic [indexWidth:0]            w_count_next;
    logic [dataWidth-1:0]           r_max;
    logic [dataWidth-1:0]           w_max_next;
    logic [indexWidth-1:0]          r_idx;
    logic [indexWidth-1:0]          w_idx_next;
    logic [indexWidth-1:0]          w_out_next;
    logic [dataWidth-1:0]           w_val_next;
    logic                           w_out_valid_next;
    logic                           r_valid_d;
    logic                           r_armed;
    logic                           w_accept;
    logic                           w_greater;
    logic [dataWidth-1:0]           w_elem;
    logic [dataWidth-1:0]           w_cand_max;
    logic [indexWidth-1:0]          w_cand_idx;
    logic [dataWidth-1:0]           w_elems [numInputs];

    for (genvar k = 0; k < numInputs; k++) begin : g_elems
        assign w_elems[k] = r_vec[(k+1)*dataWidth-1 -: dataWidth];
    end

    // r_armed blocks a level that was already high across reset from
    // looking like a fresh rising edge.
    assign w_accept   = argInValid && !r_valid_d && r_armed && (r_state == IDLE);
    assign w_elem     = w_elems[r_count[indexWidth-1:0]];
    assign w_greater  = $signed(w_elem) > $signed(r_max);
    assign w_cand_max = w_greater ? w_elem : r_max;
    assign w_cand_idx = w_greater ? r_count[indexWidth-1:0] : r_idx;
    assign busy       = (r_state == SCAN);

    always_comb begin
        w_state_next     = r_state;
        w_vec_next       = r_vec;
        w_count_next     = r_count;
        w_max_next       = r_max;
        w_idx_next       = r_idx;
        w_out_next       = argOut;
        w_val_next       = argMaxValue;
        w_out_valid_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_vec_next   = argIn;
                    w_max_next   = argIn[dataWidth-1:0];
                    w_idx_next   = '0;
                    w_count_next = (indexWidth + 1)'(1);
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                w_max_next   = w_cand_max;
                w_idx_next   = w_cand_idx;
                w_count_next = r_count + 1'b1;
                if (r_count == c_last_count) begin
                    w_out_next       = w_cand_idx;
                    w_val_next       = w_cand_max;
                    w_out_valid_next = 1'b1;
                    w_count_next     = '0;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vec       <= '0;
            r_count     <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_valid_d   <= 1'b0;
            r_armed     <= 1'b0;
            argOut      <= '0;
            argMaxValue <= '0;
            argOutValid <= 1'b0;
        end else begin
            r_vec       <= w_vec_next;
            r_count     <= w_count_next;
            r_max       <= w_max_next;
            r_idx       <= w_idx_next;
            r_valid_d   <= argInValid;
            r_armed     <= r_armed | ~argInValid;
            argOut      <= w_out_next;
            argMaxValue <= w_val_next;
            argOutValid <= w_out_valid_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_argmax
// Brief    : Directed and random checks of output_argmax against a reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_argmax;

    localparam int N = 10;
    localparam int W = 16;

    logic             clk;
    logic             reset;
    logic [W*N-1:0]   argIn;
    logic             argInValid;
    logic [3:0]       argOut;
    logic [W-1:0]     argMaxValue;
    logic             argOutValid;
    logic             busy;

    output_argmax #(.dataWidth(W), .numInputs(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .argIn       (argIn),
        .argInValid  (argInValid),
        .argOut      (argOut),
        .argMaxValue (argMaxValue),
        .argOutValid (argOutValid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cyc    = 0;
    int last_pulse_cyc = 0;

    // Reference: per accepted vector the answer is a plain loop over the
    // elements; timing is "result appears N-1 edges after acceptance".
    bit           m_prev = 1'b0;
    bit           m_armed = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_ov = 1'b0;
    int           m_left = 0;
    logic [3:0]   m_out = '0;
    logic [W-1:0] m_val = '0;
    logic [3:0]   m_exp_idx = '0;
    logic [W-1:0] m_exp_val = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W*N-1:0] pack(input logic [W-1:0] e [N]);
        logic [W*N-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = e[k];
        return v;
    endfunction

    task automatic model_edge(input bit v, input logic [W*N-1:0] vec);
        int best;
        m_ov = 1'b0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_out  = m_exp_idx;
                m_val  = m_exp_val;
                m_ov   = 1'b1;
                m_busy = 1'b0;
            end
        end else if (v && !m_prev && m_armed) begin
            best = 0;
            for (int k = 1; k < N; k++)
                if ($signed(vec[k*W +: W]) > $signed(vec[best*W +: W])) best = k;
            m_exp_idx = 4'(best);
            m_exp_val = vec[best*W +: W];
            m_busy    = 1'b1;
            m_left    = N - 1;
        end
        if (!v) m_armed = 1'b1;
        m_prev = v;
    endtask

    // Entered and left at a falling edge.
    task automatic step(input bit v, input logic [W*N-1:0] vec);
        argInValid = v;
        argIn      = vec;
        @(posedge clk);
        cyc++;
        model_edge(v, vec);
        @(negedge clk);
        check("argOutValid", 32'(argOutValid), 32'(m_ov));
        check("busy", 32'(busy), 32'(m_busy));
        check("argOut", 32'(argOut), 32'(m_out));
        check("argMaxValue", 32'(argMaxValue), 32'(m_val));
        if (argOutValid) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_argOut"}, 32'(argOut), 32'h0);
        check({tag, "_argMaxValue"}, 32'(argMaxValue), 32'h0);
        check({tag, "_argOutValid"}, 32'(argOutValid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset(input int edges);
        #2 reset = 1'b0;
        #1 check_zero("rst_async");
        m_prev = 1'b0; m_armed = 1'b0; m_busy = 1'b0; m_ov = 1'b0;
        m_out  = '0;   m_val   = '0;
        repeat (edges) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        reset = 1'b1;
    endtask

    task automatic run_vector(input string tag, input logic [W*N-1:0] v,
                              input int exp_idx, input logic [W-1:0] exp_val);
        int p0, acc;
        p0 = pulses;
        step(1'b0, v);
        acc = cyc + 1;
        step(1'b1, v);
        repeat (N + 2) step(1'b0, v);
        check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
        check({tag, "_latency"}, 32'(last_pulse_cyc - acc), 32'(N - 1));
        check({tag, "_idx"}, 32'(argOut), 32'(exp_idx));
        check({tag, "_val"}, 32'(argMaxValue), 32'(exp_val));
    endtask

    logic [W-1:0]   el [N];
    logic [W*N-1:0] va, vb;
    int             p0;

    initial begin
        reset      = 1'b0;
        argInValid = 1'b0;
        argIn      = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        el = '{16'h0100, 16'h0400, 16'h0200, 16'h7000, 16'h0000,
               16'h0010, 16'h0FFF, 16'h0001, 16'h0002, 16'h0003};
        va = pack(el);
        run_vector("distinct", va, 3, 16'h7000);

        el = '{16'hF000, 16'h8000, 16'hE000, 16'h9000, 16'hA000,
               16'hC000, 16'hFF00, 16'h8001, 16'hF000, 16'hD000};
        run_vector("negative", pack(el), 6, 16'hFF00);

        for (int k = 0; k < N; k++) el[k] = 16'h8000;
        el[4] = 16'h7FFF;
        run_vector("extremes", pack(el), 4, 16'h7FFF);

        for (int k = 0; k < N; k++) el[k] = 16'h0100;
        el[2] = 16'h0500;
        el[8] = 16'h0500;
        run_vector("tie", pack(el), 2, 16'h0500);

        // Held level: one result only, then a fresh edge starts a new scan.
        p0 = pulses;
        repeat (30) step(1'b1, va);
        check("held_pulses", 32'(pulses - p0), 32'd1);
        step(1'b0, va);
        for (int k = 0; k < N; k++) el[k] = 16'(k);
        el[9] = 16'h1234;
        vb = pack(el);
        repeat (12) step(1'b1, vb);
        check("held_pulses2", 32'(pulses - p0), 32'd2);
        check("held_idx", 32'(argOut), 32'd9);
        check("held_val", 32'(argMaxValue), 32'h1234);

        // A new edge during a scan is dropped.
        step(1'b0, va);
        p0 = pulses;
        step(1'b1, va);
        repeat (3) step(1'b0, va);
        for (int k = 0; k < N; k++) el[k] = 16'h0001;
        el[7] = 16'h7777;
        vb = pack(el);
        repeat (14) step(1'b1, vb);
        check("busy_edge_pulses", 32'(pulses - p0), 32'd1);
        check("busy_edge_idx", 32'(argOut), 32'd3);
        check("busy_edge_val", 32'(argMaxValue), 32'h7000);

        // Reset mid-scan, then wait for a real low-to-high edge.
        step(1'b0, va);
        step(1'b1, va);
        repeat (4) step(1'b1, va);
        p0 = pulses;
        do_reset(2);
        repeat (12) step(1'b1, va);
        check("post_reset_pulses", 32'(pulses - p0), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        run_vector("post_reset", va, 3, 16'h7000);

        // Random traffic; narrow value ranges provoke ties.
        va = '0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < N; k++)
                    el[k] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
                va = pack(el);
            end
            if ($urandom_range(0, 249) == 0) do_reset(1);
            step($urandom_range(0, 4) < 2, va);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
